// File: rtl/branch_predictor_pkg.sv
// Shared counter encodings, default table depth and a saturating perf-counter helper
// for the IF/EX branch predictor.
package branch_predictor_pkg;

  typedef enum logic [1:0] {
    BP_CTR_SNT = 2'b00,
    BP_CTR_WNT = 2'b01,
    BP_CTR_WT  = 2'b10,
    BP_CTR_ST  = 2'b11
  } bp_ctr_e;

  localparam int BP_ENTRIES = 16;

  function automatic logic [31:0] sat_inc32(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

endpackage

// File: rtl/branch_predictor_sat_counter2.sv
// Next-state logic of a 2-bit saturating up/down branch history counter.
module sat_counter2
  import branch_predictor_pkg::*;
(
  input  logic [1:0] i_cur,
  input  logic       i_taken,
  output logic [1:0] o_next
);

  always_comb begin
    o_next = i_cur;
    if (i_taken) begin
      if (i_cur != BP_CTR_ST) o_next = i_cur + 2'd1;
    end else begin
      if (i_cur != BP_CTR_SNT) o_next = i_cur - 2'd1;
    end
  end

endmodule

// File: rtl/branch_predictor.sv
// BHT+BTB branch predictor: combinational IF lookup, EX-stage resolve/redirect,
// and registered table training from the resolved EX outcome.
module branch_predictor
  import branch_predictor_pkg::*;
#(
  parameter int ENTRIES = BP_ENTRIES,
  parameter int XLEN    = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [XLEN-1:0] if_pc,
  output logic            pred_taken,
  output logic [XLEN-1:0] pred_target,
  input  logic            ex_valid,
  input  logic            ex_is_branch,
  input  logic [XLEN-1:0] ex_pc,
  input  logic            ex_taken,
  input  logic [XLEN-1:0] ex_target,
  input  logic            ex_pred_taken,
  input  logic [XLEN-1:0] ex_pred_target,
  output logic            mispredict,
  output logic [XLEN-1:0] redirect_pc,
  output logic [31:0]     mispredict_cnt
);

  localparam int IDX_W = $clog2(ENTRIES);
  localparam int TAG_W = XLEN - IDX_W - 2;

  logic                r_valid  [ENTRIES];
  logic [1:0]          r_ctr    [ENTRIES];
  logic [TAG_W-1:0]    r_tag    [ENTRIES];
  logic [XLEN-1:0]     r_target [ENTRIES];
  logic [31:0]         r_mis_cnt;

  logic [IDX_W-1:0]    w_if_idx, w_ex_idx;
  logic [TAG_W-1:0]    w_if_tag, w_ex_tag;
  logic                w_upd, w_alias, w_ex_hit;
  logic [1:0]          w_ctr_next;
  logic                w_unused;

  assign w_if_idx = if_pc[IDX_W+1:2];
  assign w_if_tag = if_pc[XLEN-1:IDX_W+2];
  assign w_ex_idx = ex_pc[IDX_W+1:2];
  assign w_ex_tag = ex_pc[XLEN-1:IDX_W+2];
  assign w_unused = ^{if_pc[1:0], ex_pc[1:0]};

  // IF lookup: reads the pre-update table, no bypass from the EX write
  assign pred_taken  = r_valid[w_if_idx] && (r_tag[w_if_idx] == w_if_tag) && r_ctr[w_if_idx][1];
  assign pred_target = pred_taken ? r_target[w_if_idx] : if_pc + XLEN'(4);

  // EX resolve
  assign w_upd   = ex_valid && ex_is_branch;
  assign w_alias = ex_valid && !ex_is_branch && ex_pred_taken;
  assign w_ex_hit = r_valid[w_ex_idx] && (r_tag[w_ex_idx] == w_ex_tag);

  assign mispredict = (w_upd && ((ex_taken != ex_pred_taken) ||
                                 (ex_taken && (ex_pred_target != ex_target)))) || w_alias;
  assign redirect_pc    = (w_upd && ex_taken) ? ex_target : ex_pc + XLEN'(4);
  assign mispredict_cnt = r_mis_cnt;

  sat_counter2 u_ctr (
    .i_cur   (r_ctr[w_ex_idx]),
    .i_taken (ex_taken),
    .o_next  (w_ctr_next)
  );

  // Control state: valid bits, counters and perf counter carry the reset
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < ENTRIES; i++) begin
        r_valid[i] <= 1'b0;
        r_ctr[i]   <= BP_CTR_WNT;
      end
      r_mis_cnt <= 32'd0;
    end else begin
      if (w_upd) begin
        if (w_ex_hit) begin
          r_ctr[w_ex_idx] <= w_ctr_next;
        end else if (ex_taken) begin
          r_valid[w_ex_idx] <= 1'b1;
          r_ctr[w_ex_idx]   <= BP_CTR_WT;
        end
      end
      if (w_alias) r_valid[w_ex_idx] <= 1'b0;
      if (mispredict) r_mis_cnt <= sat_inc32(r_mis_cnt);
    end
  end

  // Data state: tag/target are only meaningful behind a valid bit, so they are not reset
  always_ff @(posedge clk) begin
    if (!rst && w_upd && ex_taken) begin
      r_target[w_ex_idx] <= ex_target;
      if (!w_ex_hit) r_tag[w_ex_idx] <= w_ex_tag;
    end
  end

endmodule

// File: tb/tb_branch_predictor.sv
// Self-checking bench for branch_predictor: directed scenarios then randomized
// traffic against a table-level reference model.
module tb_branch_predictor;

  localparam int ENTRIES = 16;
  localparam int IDX_W   = $clog2(ENTRIES);

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] if_pc;
  logic        pred_taken;
  logic [31:0] pred_target;
  logic        ex_valid, ex_is_branch, ex_taken, ex_pred_taken;
  logic [31:0] ex_pc, ex_target, ex_pred_target;
  logic        mispredict;
  logic [31:0] redirect_pc;
  logic [31:0] mispredict_cnt;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state
  bit          m_valid  [ENTRIES];
  int unsigned m_tag    [ENTRIES];
  logic [31:0] m_target [ENTRIES];
  int          m_ctr    [ENTRIES];
  longint      m_cnt;

  branch_predictor #(.ENTRIES(ENTRIES), .XLEN(32)) dut (
    .clk            (clk),
    .rst            (rst),
    .if_pc          (if_pc),
    .pred_taken     (pred_taken),
    .pred_target    (pred_target),
    .ex_valid       (ex_valid),
    .ex_is_branch   (ex_is_branch),
    .ex_pc          (ex_pc),
    .ex_taken       (ex_taken),
    .ex_target      (ex_target),
    .ex_pred_taken  (ex_pred_taken),
    .ex_pred_target (ex_pred_target),
    .mispredict     (mispredict),
    .redirect_pc    (redirect_pc),
    .mispredict_cnt (mispredict_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int m_idx(input logic [31:0] pc);
    return int'((pc >> 2) % ENTRIES);
  endfunction

  function automatic int unsigned m_tagof(input logic [31:0] pc);
    return pc >> (IDX_W + 2);
  endfunction

  function automatic void m_predict(input logic [31:0] pc, output bit tk, output logic [31:0] tgt);
    int i = m_idx(pc);
    tk  = m_valid[i] && (m_tag[i] == m_tagof(pc)) && (m_ctr[i] >= 2);
    tgt = tk ? m_target[i] : pc + 32'd4;
  endfunction

  function automatic void m_reset();
    for (int i = 0; i < ENTRIES; i++) begin
      m_valid[i] = 1'b0;
      m_ctr[i]   = 1;
    end
    m_cnt = 0;
  endfunction

  // One clock: drive at negedge, check combinational outputs mid-cycle, train model at posedge
  task automatic cyc(input bit r, input logic [31:0] ipc, input bit v, input bit br,
                     input logic [31:0] epc, input bit tk, input logic [31:0] tgt,
                     input bit ptk, input logic [31:0] ptgt);
    bit          e_tk, e_mis, hit;
    logic [31:0] e_tgt, e_red;
    int          i;
    @(negedge clk);
    rst = r; if_pc = ipc; ex_valid = v; ex_is_branch = br; ex_pc = epc;
    ex_taken = tk; ex_target = tgt; ex_pred_taken = ptk; ex_pred_target = ptgt;
    #1;
    m_predict(ipc, e_tk, e_tgt);
    e_mis = (v && br && ((tk != ptk) || (tk && ptgt != tgt))) || (v && !br && ptk);
    e_red = (v && br && tk) ? tgt : epc + 32'd4;
    check("pred_taken", 64'(pred_taken), 64'(e_tk));
    check("pred_target", 64'(pred_target), 64'(e_tgt));
    check("mispredict", 64'(mispredict), 64'(e_mis));
    check("redirect_pc", 64'(redirect_pc), 64'(e_red));
    check("mispredict_cnt", 64'(mispredict_cnt), 64'(m_cnt));
    @(posedge clk);
    if (r) begin
      m_reset();
    end else begin
      i = m_idx(epc);
      if (v && br) begin
        hit = m_valid[i] && (m_tag[i] == m_tagof(epc));
        if (hit) begin
          m_ctr[i] = tk ? ((m_ctr[i] < 3) ? m_ctr[i] + 1 : 3) : ((m_ctr[i] > 0) ? m_ctr[i] - 1 : 0);
          if (tk) m_target[i] = tgt;
        end else if (tk) begin
          m_valid[i] = 1'b1; m_tag[i] = m_tagof(epc); m_target[i] = tgt; m_ctr[i] = 2;
        end
      end
      if (v && !br && ptk) m_valid[i] = 1'b0;
      if (e_mis && m_cnt < 64'hFFFF_FFFF) m_cnt++;
    end
  endtask

  task automatic idle(input logic [31:0] ipc);
    cyc(0, ipc, 0, 0, 32'h0, 0, 32'h0, 0, 32'h0);
  endtask

  function automatic logic [31:0] pick_pc();
    int k = $urandom_range(0, 48);
    if (k == 48) return 32'hFFFF_FFFC;
    return 32'h100 + 32'((k % 16) * 4) + 32'((k / 16) * 32'h40);
  endfunction

  initial begin
    bit          r, v, br, tk, ptk, mtk;
    logic [31:0] ipc, epc, tgt, ptgt, mtgt;

    // First reset: DUT state unknown before it, so no checks on this edge
    @(negedge clk);
    rst = 1'b1; if_pc = 32'h100; ex_valid = 0; ex_is_branch = 0; ex_pc = 0;
    ex_taken = 0; ex_target = 0; ex_pred_taken = 0; ex_pred_target = 0;
    @(posedge clk);
    m_reset();

    // 1: post-reset lookup
    idle(32'h100);
    check("rst_pred_target_const", 64'(pred_target), 64'h104);

    // 2: cold taken branch allocates; same-cycle IF on that index still sees old entry
    cyc(0, 32'h100, 1, 1, 32'h100, 1, 32'h80, 0, 32'h104);
    check("cold_redirect_const", 64'(redirect_pc), 64'h80);
    idle(32'h100);
    check("cold_trained_target_const", 64'(pred_target), 64'h80);

    // 3: hysteresis
    cyc(0, 32'h100, 1, 1, 32'h100, 1, 32'h80, 1, 32'h80);
    cyc(0, 32'h100, 1, 1, 32'h100, 0, 32'h80, 1, 32'h80);
    check("hyst_redirect_const", 64'(redirect_pc), 64'h104);
    idle(32'h100);
    cyc(0, 32'h100, 1, 1, 32'h100, 0, 32'h80, 1, 32'h80);
    idle(32'h100);
    check("hyst_not_taken_const", 64'(pred_taken), 64'h0);

    // 4: alias on same index replaces entry
    cyc(0, 32'h140, 1, 1, 32'h140, 1, 32'h200, 0, 32'h144);
    idle(32'h100);
    idle(32'h140);
    check("alias_new_target_const", 64'(pred_target), 64'h200);

    // 5: predicted-taken non-branch invalidates the entry
    cyc(0, 32'h140, 1, 0, 32'h140, 0, 32'h0, 1, 32'h200);
    check("nonbr_redirect_const", 64'(redirect_pc), 64'h144);
    idle(32'h140);

    // 6: bubble with branch-looking inputs has no effect
    cyc(0, 32'h100, 1, 1, 32'h100, 1, 32'h300, 0, 32'h104);
    cyc(0, 32'h100, 0, 1, 32'h100, 0, 32'h500, 1, 32'h700);
    idle(32'h100);

    // Reset mid-training wipes history
    cyc(1, 32'h100, 0, 0, 32'h0, 0, 32'h0, 0, 32'h0);
    idle(32'h100);

    // Randomized traffic
    for (int n = 0; n < 600; n++) begin
      r    = ($urandom_range(0, 99) < 2);
      ipc  = pick_pc() | 32'($urandom_range(0, 3) * ($urandom_range(0, 7) == 0));
      epc  = pick_pc();
      v    = r ? 1'b0 : ($urandom_range(0, 9) != 0);
      br   = ($urandom_range(0, 4) != 0);
      tk   = $urandom_range(0, 1);
      tgt  = {$urandom_range(0, 255), 2'b00} + 32'h1000;
      if ($urandom_range(0, 7) == 0) tgt = 32'hFFFF_FFFC;
      m_predict(epc, mtk, mtgt);
      if ($urandom_range(0, 9) < 7) begin
        ptk = mtk; ptgt = mtgt;
      end else begin
        ptk = $urandom_range(0, 1);
        ptgt = $urandom_range(0, 1) ? tgt : {$urandom_range(0, 255), 2'b00};
      end
      cyc(r, ipc, v, br, epc, tk, tgt, ptk, ptgt);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
